// File: rtl/reg_file_mem_pkg.sv
// ============================================================================
// mem_pkg : shared types and helpers for the reg_file_mem word store
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Even parity bit: makes the total number of ones (data + parity) even.
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_mem_if.sv
// ============================================================================
// reg_file_mem_if : write/read/clear bus of the reg_file_mem word store
// Optional REG_FILE_MEM_PARITY_EN adds perr (read side) and pinj (write side).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_file_mem_if
  import mem_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
);
  localparam int AW = addr_w(DEPTH);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wd;
  logic             re;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rd;
  logic             rvalid;
  logic             clr;
  logic             busy;
`ifdef REG_FILE_MEM_PARITY_EN
  logic             perr;
  logic             pinj;
`endif

  modport slave (
    input  we, waddr, wd, re, raddr, clr,
`ifdef REG_FILE_MEM_PARITY_EN
    input  pinj,
    output perr,
`endif
    output rd, rvalid, busy
  );

  modport master (
    output we, waddr, wd, re, raddr, clr,
`ifdef REG_FILE_MEM_PARITY_EN
    output pinj,
    input  perr,
`endif
    input  rd, rvalid, busy
  );

endinterface

`default_nettype wire

// File: rtl/reg_file_mem_clr_seq.sv
// ============================================================================
// clr_seq : clear sweep sequencer; walks a pointer over every word after
//           reset or a clear request and presents it as a write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clr_seq
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = addr_w(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          clr,
  output logic               busy,
  output logic               sweep_we,
  output logic [AW-1:0]      sweep_addr
);

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEARING;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEARING;
          ptr_nxt   = '0;
        end
      end
      ST_CLEARING: begin
        // A clear request mid-sweep restarts the walk rather than finishing it.
        if (clr) begin
          ptr_nxt = '0;
        end else if (ptr == AW'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_CLEARING;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    busy       = (state == ST_CLEARING);
    sweep_we   = (state == ST_CLEARING);
    sweep_addr = ptr;
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_mem.sv
// ============================================================================
// reg_file_mem : clocked word memory, one write port, one registered read
//                port with write-first bypass, built-in clear sweep.
// Optional macro REG_FILE_MEM_PARITY_EN adds per-word even parity.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file_mem
  import mem_pkg::*;
#(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input wire logic      clk,
  input wire logic      rst,
  reg_file_mem_if.slave bus
);

  localparam int AW = addr_w(DEPTH);
`ifdef REG_FILE_MEM_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  logic          busy;
  logic          sweep_we;
  logic [AW-1:0] sweep_addr;

  clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.clr),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  assign bus.busy = busy;

  logic [SW-1:0] mem [DEPTH];
  logic          waddr_ok, raddr_ok, mem_we;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata, user_word, clr_word, rword;

  assign waddr_ok = (32'(bus.waddr) < 32'(DEPTH));
  assign raddr_ok = (32'(bus.raddr) < 32'(DEPTH));

`ifdef REG_FILE_MEM_PARITY_EN
  assign user_word = {even_par(64'(bus.wd)) ^ bus.pinj, bus.wd};
  assign clr_word  = {even_par(64'(CLR_VAL)), CLR_VAL};
`else
  assign user_word = bus.wd;
  assign clr_word  = CLR_VAL;
`endif

  // The sweep owns the single write port whenever it is running.
  always_comb begin
    mem_we    = busy ? sweep_we : (bus.we && waddr_ok);
    mem_addr  = busy ? sweep_addr : bus.waddr;
    mem_wdata = busy ? clr_word : user_word;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign rword = mem[bus.raddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd     <= '0;
      bus.rvalid <= 1'b0;
`ifdef REG_FILE_MEM_PARITY_EN
      bus.perr   <= 1'b0;
`endif
    end else if (!busy && bus.re) begin
      bus.rvalid <= 1'b1;
      if (!raddr_ok) begin
        bus.rd <= '0;
`ifdef REG_FILE_MEM_PARITY_EN
        bus.perr <= 1'b0;
`endif
      end else if (bus.we && (bus.waddr == bus.raddr)) begin
        bus.rd <= bus.wd;
`ifdef REG_FILE_MEM_PARITY_EN
        bus.perr <= 1'b0;
`endif
      end else begin
        bus.rd <= rword[WIDTH-1:0];
`ifdef REG_FILE_MEM_PARITY_EN
        // Stored parity plus data has odd weight exactly when they disagree.
        bus.perr <= ^rword;
`endif
      end
    end else begin
      bus.rvalid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/reg_file_mem.md
Name: reg_file_mem

Overview:
Parametrised, clocked word memory: the synchronous successor to the latch-based 4x3 word store. It provides a single write port, a single registered read port with write-first bypass, and a built-in clear sequencer that sweeps every word to a known value after reset or on request. It is intended as the general storage primitive for later datapath blocks.

Parameters:
WIDTH, 3, data bits per word
DEPTH, 4, number of words (>=2; need not be a power of two)
CLR_VAL, 0, WIDTH-bit value written to every word by the clear sweep

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
WE  input  1  write request
WADDR  input  AW  write address, AW = max(1, clog2(DEPTH))
WD  input  WIDTH  write data
RE  input  1  read request
RADDR  input  AW  read address
RD  output  WIDTH  read data, registered
RVALID  output  1  one-cycle pulse: RD holds the result of a read accepted in the previous cycle
CLR  input  1  start a clear sweep (level sampled each cycle)
BUSY  output  1  clear sweep in progress; requests ignored

Behaviour:
- Reset values: while RST is high and at its release, RD=0, RVALID=0, BUSY=1, state=CLEARING, sweep pointer=0. The array itself is not reset asynchronously; the sweep initialises it.
- States: IDLE and CLEARING.
  - CLEARING: each cycle writes CLR_VAL to mem[ptr] and increments ptr.
  - On the cycle that writes ptr==DEPTH-1, the next state is IDLE and BUSY drops on that same edge.
  - BUSY is therefore high for exactly DEPTH cycles after RST is released.
- CLR in IDLE: next cycle enters CLEARING with ptr=0.
- CLR in CLEARING: restarts ptr at 0, extending the sweep.
- RST mid-sweep: restarts the sweep from 0.
- While BUSY=1: WE and RE are ignored. RVALID stays 0 and RD holds its value.
- Write (IDLE, WE=1, WADDR<DEPTH): mem[WADDR]<=WD at the rising edge. WADDR>=DEPTH: the write is dropped silently.
- Read (IDLE, RE=1) at edge n: RD and RVALID=1 update at edge n, visible during cycle n+1. Latency is 1.
  - RVALID returns to 0 after one cycle unless RE is held. Back-to-back reads give one result per cycle.
  - RADDR>=DEPTH: RD=0, RVALID=1.
  - Same-cycle WE and RE to the same valid address: RD returns WD (write-first bypass).
- RD holds its last value when no read is accepted.
- CLR and WE together in IDLE: the write is performed; the sweep starts the next cycle and overwrites it.
- CLR and RE together in IDLE: the read completes normally.

Optional Feature:
REG_FILE_MEM_PARITY_EN
- Defined:
  - Each word stores WIDTH+1 bits, with an even parity bit computed from WD on write. The clear sweep stores the correct parity for CLR_VAL.
  - Extra output PERR (1 bit) updates with RD. PERR=1 if the stored parity mismatches the stored data of the word read. Out-of-range reads give PERR=0; the bypass path gives PERR=0. Reset value is 0.
  - Extra input PINJ (1 bit): when high during an accepted write, the stored parity bit is inverted (error injection).
- Undefined: PERR and PINJ ports do not exist, storage is WIDTH bits, and behaviour is otherwise identical.

Decomposition:
- Package mem_pkg:
  - state enum ST_IDLE/ST_CLEARING
  - function addr_w(depth) returning max(1, clog2(depth))
  - function even_par(vector)
- Sub-module clr_seq:
  - Owns the state register, sweep pointer, BUSY, and the sweep write address/enable.
  - reg_file_mem muxes the sweep write port against the user write port.

Test Plan:
- Reset release, WIDTH=3, DEPTH=4, CLR_VAL=5 -> BUSY=1 for exactly 4 cycles. Then reads of addresses 0..3 each return 5 with RVALID pulsing one cycle after RE.
- IDLE: write 3'b110 to addr 2, then read addr 2 next cycle -> RD=6, RVALID=1 one cycle later. Read addr 1 -> RD=CLR_VAL.
- Same-cycle WE=1, WADDR=1, WD=3 and RE=1, RADDR=1 (old value 5) -> RD=3 next cycle. Re-read -> 3.
- DEPTH=5 (AW=3): write to addr 6 is dropped; read addr 6 -> RD=0, RVALID=1; addr 0..4 unchanged.
- CLR pulse, then RST asserted at sweep cycle 2 -> outputs reset immediately. After release, BUSY is high for the full DEPTH cycles; RE issued during BUSY -> no RVALID.
- With REG_FILE_MEM_PARITY_EN: write 3'b011 with PINJ=1 to addr 0, then read -> PERR=1. Rewrite with PINJ=0, then read -> PERR=0. Reads after CLR -> PERR=0.
